// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  // Controller states: idle/capture, bus request outstanding, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Value returned on the load-data path when an access fails.
  localparam int ERR_DATA = 0;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Saturating cycle counter that flags a bus request exceeding its cycle budget.
// Latency: expired is combinational from the registered count and en.
// Backpressure: none; clr wins over en, count holds at TIMEOUT.
//
// Ports: clk, rst (async, active-high), clr (zero the count), en (count this
// cycle), expired (high during the TIMEOUT-th enabled cycle and beyond).
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX_CNT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of REQ cycles already completed, so the current
  // cycle is the TIMEOUT-th one when cnt reaches TIMEOUT-1.
  assign expired = en && (cnt >= LAST_CNT);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns MEM-stage load/store requests into a
// registered req/ack transaction on a variable-latency SRAM bus.
// Latency: 3 cycles minimum (capture, REQ with ack, DONE); +1 per wait cycle.
// Backpressure: stall_req_o holds the pipeline while the access is pending.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   rmem_i, wmem_i                   load / store request (load wins)
//   mem_raddr_i, mem_waddr_i         load / store address
//   mem_wdata_i                      store data
//   rdata_o                          load data, meaningful in DONE
//   stall_req_o                      pipeline hold (combinational)
//   bus_err_o                        misalign / timeout flag, in DONE
//   sram_req_o, sram_we_o            bus request, write enable
//   sram_addr_o, sram_wdata_o        bus address, write data
//   sram_ack_i, sram_rdata_i         completion strobe, read data
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rmem_i,
  input  logic              wmem_i,
  input  logic [ADDR_W-1:0] mem_raddr_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              stall_req_o,
  output logic              bus_err_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic              sram_ack_i,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              err_q;

  logic              mem_req;
  logic [ADDR_W-1:0] sel_addr;
  logic              misaligned;
  logic              cnt_clr;
  logic              cnt_en;
  logic              expired;

  assign mem_req    = rmem_i | wmem_i;
  assign sel_addr   = rmem_i ? mem_raddr_i : mem_waddr_i;
  assign misaligned = !is_aligned(sel_addr[1:0]);

  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          state_n = misaligned ? DONE : REQ;
          cnt_clr = !misaligned;
        end
      end
      REQ: begin
        cnt_en = 1'b1;
        // An ack in the last allowed cycle still completes cleanly.
        if (sram_ack_i || expired) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q  <= sel_addr;
            wdata_q <= mem_wdata_i;
            we_q    <= !rmem_i;
            err_q   <= misaligned;
            if (misaligned) begin
              rdata_q <= DATA_W'(ERR_DATA);
            end
          end
        end
        REQ: begin
          if (sram_ack_i) begin
            err_q <= 1'b0;
            if (!we_q) begin
              rdata_q <= sram_rdata_i;
            end
          end else if (expired) begin
            err_q   <= 1'b1;
            rdata_q <= DATA_W'(ERR_DATA);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Low in DONE so the pipeline advances on the edge that ends DONE.
  assign stall_req_o  = !rst && (((state == IDLE) && mem_req) || (state == REQ));
  assign sram_req_o   = (state == REQ);
  assign sram_we_o    = we_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;
  assign bus_err_o    = (state == DONE) && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rmem_i, wmem_i;
  logic [31:0] mem_raddr_i, mem_waddr_i, mem_wdata_i;
  logic [31:0] rdata_o;
  logic        stall_req_o, bus_err_o;
  logic        sram_req_o, sram_we_o;
  logic [31:0] sram_addr_o, sram_wdata_o;
  logic        sram_ack_i;
  logic [31:0] sram_rdata_i;

  int checks   = 0;
  int failures = 0;

  // Reference state: last value the load-data path should hold.
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rmem_i       (rmem_i),
    .wmem_i       (wmem_i),
    .mem_raddr_i  (mem_raddr_i),
    .mem_waddr_i  (mem_waddr_i),
    .mem_wdata_i  (mem_wdata_i),
    .rdata_o      (rdata_o),
    .stall_req_o  (stall_req_o),
    .bus_err_o    (bus_err_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_ack_i   (sram_ack_i),
    .sram_rdata_i (sram_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One memory op. Called at posedge+1 with the DUT idle; returns at
  // posedge+1 after the edge that ends DONE. lat = REQ cycle carrying the
  // ack (0 = never acked). rv = read data the bus returns with the ack.
  task automatic run_op(input bit rd, input bit wr, input logic [31:0] ra,
                        input logic [31:0] wa, input logic [31:0] wd,
                        input int lat, input logic [31:0] rv);
    logic [31:0] ea;
    bit          ewe, eerr, done;
    int          exp_req, exp_stall, nreq, nstall;
    ea  = rd ? ra : wa;
    ewe = !rd;
    if (ea[1:0] != 2'b00) begin
      exp_req = 0; exp_stall = 1; eerr = 1'b1; m_rdata = 32'h0;
    end else if (lat >= 1 && lat <= TO) begin
      exp_req = lat; exp_stall = lat + 1; eerr = 1'b0;
      if (rd) m_rdata = rv;
    end else begin
      exp_req = TO; exp_stall = TO + 1; eerr = 1'b1; m_rdata = 32'h0;
    end
    rmem_i = rd; wmem_i = wr;
    mem_raddr_i = ra; mem_waddr_i = wa; mem_wdata_i = wd;
    nreq = 0; nstall = 0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (sram_req_o) begin
        nreq++;
        chk("req_addr", sram_addr_o, ea);
        chk("req_we", {31'b0, sram_we_o}, {31'b0, ewe});
        if (ewe) chk("req_wdata", sram_wdata_o, wd);
        sram_ack_i   = (nreq == lat);
        sram_rdata_i = (nreq == lat) ? rv : $urandom;
      end else begin
        // Stray acks outside REQ must have no effect.
        sram_ack_i   = $urandom_range(0, 1);
        sram_rdata_i = $urandom;
      end
      @(negedge clk);
      if (stall_req_o) begin
        nstall++;
      end else begin
        done = 1'b1;
        chk("done_rdata", rdata_o, m_rdata);
        chk("done_err", {31'b0, bus_err_o}, {31'b0, eerr});
        chk("req_cycles", nreq, exp_req);
        chk("stall_cycles", nstall, exp_stall);
      end
      @(posedge clk); #1;
    end
    if (!done) chk("op_no_done", 32'd0, 32'd1);
    rmem_i = 1'b0; wmem_i = 1'b0; sram_ack_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sram_ack_i   = $urandom_range(0, 1);
      sram_rdata_i = $urandom;
      @(negedge clk);
      chk("idle_stall", {31'b0, stall_req_o}, 32'd0);
      chk("idle_req", {31'b0, sram_req_o}, 32'd0);
      chk("idle_rdata", rdata_o, m_rdata);
      @(posedge clk); #1;
    end
    sram_ack_i = 1'b0;
  endtask

  task automatic reset_mid_req();
    rmem_i = 1'b1; wmem_i = 1'b0; mem_raddr_i = 32'h40;
    mem_waddr_i = 32'h0; mem_wdata_i = 32'hDEAD_BEEF; sram_ack_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_req", {31'b0, sram_req_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    m_rdata = 32'h0;
    chk("rst_req", {31'b0, sram_req_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_req_o}, 32'd0);
    chk("rst_err", {31'b0, bus_err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_we", {31'b0, sram_we_o}, 32'd0);
    chk("rst_addr", sram_addr_o, 32'd0);
    chk("rst_wdata", sram_wdata_o, 32'd0);
    rmem_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    sram_ack_i = 1'b1; sram_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_ack_req", {31'b0, sram_req_o}, 32'd0);
    chk("late_ack_stall", {31'b0, stall_req_o}, 32'd0);
    @(posedge clk); #1;
    sram_ack_i = 1'b0;
    idle_cycles(2);
  endtask

  initial begin
    logic [31:0] a, wa;
    bit rd, wr;
    int lat;
    rst = 1'b1;
    rmem_i = 1'b1; wmem_i = 1'b1;
    mem_raddr_i = 32'h100; mem_waddr_i = 32'h200; mem_wdata_i = 32'h0;
    sram_ack_i = 1'b0; sram_rdata_i = 32'h0;
    m_rdata = 32'h0;
    #2;
    chk("reset_stall", {31'b0, stall_req_o}, 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_err", {31'b0, bus_err_o}, 32'd0);
    chk("reset_req", {31'b0, sram_req_o}, 32'd0);
    chk("reset_we", {31'b0, sram_we_o}, 32'd0);
    chk("reset_addr", sram_addr_o, 32'd0);
    chk("reset_wdata", sram_wdata_o, 32'd0);
    rmem_i = 1'b0; wmem_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    idle_cycles(2);

    run_op(1, 0, 32'h0000_0100, 32'h0, 32'h0, 3, 32'h1234_5678);
    run_op(0, 1, 32'h0, 32'h0000_0204, 32'hA5A5_A5A5, 1, 32'h0BAD_0BAD);
    run_op(1, 1, 32'h0000_0010, 32'h0000_0020, 32'h5555_AAAA, 2, 32'hCAFE_F00D);
    run_op(1, 0, 32'h0000_0102, 32'h0, 32'h0, 1, 32'h1111_1111);
    run_op(1, 0, 32'h0000_0300, 32'h0, 32'h0, 0, 32'h2222_2222);
    run_op(1, 0, 32'h0000_0304, 32'h0, 32'h0, 4, 32'h3333_3333);
    run_op(0, 1, 32'h0, 32'h0000_0400, 32'h4444_4444, 0, 32'h0);
    run_op(0, 1, 32'h0, 32'h0000_0401, 32'h4444_4444, 2, 32'h0);
    idle_cycles(1);

    reset_mid_req();

    for (int n = 0; n < 150; n++) begin
      rd = $urandom_range(0, 1);
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = $urandom & 32'hFFFF_FFFC;
      wa = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) a  = a  | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) wa = wa | 32'($urandom_range(1, 3));
      lat = $urandom_range(0, TO + 2);
      run_op(rd, wr, a, wa, $urandom, lat, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
